// File: rtl/div8s4u_seq.sv
// Sequential signed-by-unsigned restoring divider: 2W-bit signed dividend / W-bit unsigned divisor.
// Optional multiply-back self-check enabled by defining DIVSU_MULCHECK_EN.
module div8s4u_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quo,
    output logic [W:0]       rem,
    output logic             dz,
    output logic             chk_err
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*W-1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            dzf_q, dzf_d;
    // Holds |dividend| on entry; quotient bits shift in from the LSB as dividend bits leave the MSB.
    logic [2*W-1:0]  mag_q, mag_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    r_q, r_d;
    logic [2*W-1:0]  quo_q, quo_d;
    logic [W:0]      rem_q, rem_d;
    logic            dz_q, dz_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W:0]      rr;
    logic            ge;
`ifdef DIVSU_MULCHECK_EN
    logic [2*W-1:0]  dvd_q, dvd_d;
    logic [2*W-1:0]  prod;
    logic            chk_err_q, chk_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        dzf_d       = dzf_q;
        mag_d       = mag_q;
        dvs_d       = dvs_q;
        r_d         = r_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        rr          = '0;
        ge          = 1'b0;
`ifdef DIVSU_MULCHECK_EN
        dvd_d       = dvd_q;
        chk_err_d   = chk_err_q;
        prod        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    neg_d      = dividend[2*W-1];
                    mag_d      = dividend[2*W-1] ? -dividend : dividend;
                    dvs_d      = divisor;
                    r_d        = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
`ifdef DIVSU_MULCHECK_EN
                    dvd_d      = dividend;
`endif
                    if (divisor == '0) begin
                        dzf_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        dzf_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rr    = {r_q, mag_q[2*W-1]};
                ge    = (rr >= {1'b0, dvs_q});
                // Result is below the divisor, so the low W bits of the difference are exact.
                r_d   = ge ? (rr[W-1:0] - dvs_q) : rr[W-1:0];
                mag_d = {mag_q[2*W-2:0], ge};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (dzf_q) begin
                    quo_d = '1;
                    rem_d = '0;
                    dz_d  = 1'b1;
                end else begin
                    quo_d = neg_q ? -mag_q : mag_q;
                    rem_d = neg_q ? -{1'b0, r_q} : {1'b0, r_q};
                    dz_d  = 1'b0;
                end
`ifdef DIVSU_MULCHECK_EN
                // Modulo-2^(2W) arithmetic is enough: a correct result reproduces the dividend exactly.
                prod      = quo_d * {{W{1'b0}}, dvs_q} + {{(W-1){rem_d[W]}}, rem_d};
                chk_err_d = !dzf_q && (prod != dvd_q);
`endif
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dzf_q       <= 1'b0;
            mag_q       <= '0;
            dvs_q       <= '0;
            r_q         <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIVSU_MULCHECK_EN
            dvd_q       <= '0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            dzf_q       <= dzf_d;
            mag_q       <= mag_d;
            dvs_q       <= dvs_d;
            r_q         <= r_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIVSU_MULCHECK_EN
            dvd_q       <= dvd_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quo       = quo_q;
    assign rem       = rem_q;
    assign dz        = dz_q;
`ifdef DIVSU_MULCHECK_EN
    assign chk_err   = chk_err_q;
`else
    assign chk_err   = 1'b0;
`endif
endmodule

// File: tb/tb_div8s4u_seq.sv
// Self-checking bench for div8s4u_seq: directed cases, mid-operation reset, exhaustive sweep and random ops.
module tb_div8s4u_seq;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] quo;
    logic [W:0]     rem;
    logic           dz;
    logic           chk_err;

    int n_tests = 0;
    int n_fail  = 0;

    div8s4u_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quo(quo), .rem(rem), .dz(dz), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // C-style truncating division; divide-by-zero yields quo=-1, rem=0.
    task automatic ref_div(input int a, input int b, output int q, output int r, output bit z);
        if (b == 0) begin
            q = -1; r = 0; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    task automatic do_op(input logic signed [2*W-1:0] a, input logic [W-1:0] b, input int hold);
        int q, r, lat;
        bit z;
        ref_div(int'(a), int'(b), q, r, z);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        check("latency", lat, (b == 0) ? 2 : 2*W+2);
        check("quo", quo, q & 32'hFF);
        check("rem", rem, r & 32'h1F);
        check("dz", dz, z);
        check("chk_err", chk_err, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_quo", quo, q & 32'hFF);
            check("hold_rem", rem, r & 32'h1F);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("consumed_valid", out_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quo", quo, 0);
        check("rst_rem", rem, 0);
        check("rst_dz", dz, 0);
        check("rst_chk_err", chk_err, 0);
        @(negedge clk); rst = 1'b0;

        do_op(8'sd100, 4'd7, 0);
        do_op(-8'sd100, 4'd7, 0);
        do_op(8'sh80, 4'd1, 0);
        do_op(8'sd37, 4'd0, 0);
        do_op(8'sd127, 4'd15, 5);
        do_op(8'sd9, 4'd4, 0);

        // Reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; dividend = 8'd77; divisor = 4'd5;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_quo", quo, 0);
        check("midrst_rem", rem, 0);
        check("midrst_dz", dz, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_no_valid", out_valid, 0);
        end
        do_op(8'sd50, 4'd3, 0);

        for (int a = -128; a < 128; a++)
            for (int b = 0; b < 16; b++)
                do_op(8'(a), 4'(b), 0);

        for (int i = 0; i < 200; i++)
            do_op(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
